// File: rtl/window_conv.sv
// window_conv: per-channel signed WIN_SIZE x WIN_SIZE convolution of a window stream, rounded and clamped to video pixels
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   coef_i                        kernel, tap k at [(k+1)*COEF_WIDTH-1 -: COEF_WIDTH], latched on a tuser beat
//   window_t{valid,ready,data,last,user}  input window stream, pixel k at [(k+1)*PX_WIDTH-1 -: PX_WIDTH]
//   video_t{valid,ready,data,last,user}   output pixel stream, result in [PX_WIDTH-1:0]
module window_conv #(
  parameter int TDATA_WIDTH = 32,
  parameter int PX_WIDTH = 30,
  parameter int CH_CNT = 3,
  parameter int WIN_SIZE = 5,
  parameter int COEF_WIDTH = 8,
  parameter int FRAC_BITS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [WIN_SIZE*WIN_SIZE*COEF_WIDTH-1:0] coef_i,
  input  logic window_tvalid,
  output logic window_tready,
  input  logic [WIN_SIZE*WIN_SIZE*PX_WIDTH-1:0] window_tdata,
  input  logic window_tlast,
  input  logic window_tuser,
  output logic video_tvalid,
  input  logic video_tready,
  output logic [TDATA_WIDTH-1:0] video_tdata,
  output logic video_tlast,
  output logic video_tuser
);
  localparam int N = WIN_SIZE * WIN_SIZE;
  localparam int CW = PX_WIDTH / CH_CNT;
  localparam int A = $clog2(N);
  localparam int P = 1 << A;
  localparam int AW = CW + 1 + COEF_WIDTH + A;
  localparam int RND = (1 << FRAC_BITS) >> 1;
  localparam logic [N*COEF_WIDTH-1:0] IDENT = (N*COEF_WIDTH)'(1 << FRAC_BITS) << ((N - 1) / 2 * COEF_WIDTH);
  logic adv, load;
  logic [N*COEF_WIDTH-1:0] coef_q;
  logic [P*COEF_WIDTH-1:0] cf;
  logic [P*PX_WIDTH-1:0] px;
  logic signed [AW-1:0] prod [CH_CNT][P];
  // heap-ordered adder tree: node j sums 2j+1 and 2j+2, leaves at P-1..2P-2, root at 0
  logic signed [AW-1:0] node [CH_CNT][2*P-1];
  logic signed [AW-1:0] r [CH_CNT];
  logic [A+1:0] vld, lst, usr;
  logic [CH_CNT*CW-1:0] res, out_q;

  assign adv = !video_tvalid || video_tready;
  assign window_tready = adv;
  assign load = window_tvalid && adv && window_tuser;
  // a frame-start beat already uses the kernel it loads
  assign cf = (P*COEF_WIDTH)'(window_tuser ? coef_i : coef_q);
  // zero padding up to a power of two keeps the tree uniform; padded taps multiply by zero
  assign px = (P*PX_WIDTH)'(window_tdata);
  assign video_tvalid = vld[A+1];
  assign video_tlast = lst[A+1];
  assign video_tuser = usr[A+1];
  assign video_tdata = TDATA_WIDTH'(out_q);

  always_comb
    for (int c = 0; c < CH_CNT; c++)
      for (int j = 0; j < P; j++)
        prod[c][j] = AW'($signed({1'b0, px[j*PX_WIDTH+c*CW +: CW]})) * AW'($signed(cf[j*COEF_WIDTH +: COEF_WIDTH]));

  always_comb
    for (int c = 0; c < CH_CNT; c++) begin
      r[c] = (node[c][0] + AW'(RND)) >>> FRAC_BITS;
      res[c*CW +: CW] = r[c] < 0 ? '0 : r[c] > AW'((1 << CW) - 1) ? '1 : r[c][CW-1:0];
    end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      coef_q <= IDENT;
      node <= '{default: '0};
      {vld, lst, usr} <= '0;
      out_q <= '0;
    end else if (adv) begin
      if (load) coef_q <= coef_i;
      vld <= {vld[A:0], window_tvalid};
      lst <= {lst[A:0], window_tvalid & window_tlast};
      usr <= {usr[A:0], window_tvalid & window_tuser};
      out_q <= res;
      for (int c = 0; c < CH_CNT; c++) begin
        for (int j = 0; j < P - 1; j++) node[c][j] <= node[c][2*j+1] + node[c][2*j+2];
        for (int j = 0; j < P; j++) node[c][P-1+j] <= prod[c][j];
      end
    end
endmodule

// File: tb/tb_window_conv.sv
// tb_window_conv: randomized and directed checks of window_conv (3x3) against a behavioural convolution model
module tb_window_conv;
  localparam int N = 9, PXW = 30, CW = 10, KW = 8;
  typedef struct packed { logic [31:0] d; logic l; logic u; } beat_t;
  logic clk = 0, rst = 1;
  logic [N*KW-1:0] coef = '0;
  logic wv = 0, wl = 0, wu = 0, vr = 1;
  logic [N*PXW-1:0] wd = '0;
  logic wr, vv, vl, vu;
  logic [31:0] vd;
  beat_t exp_q[$], got_q[$];
  bit rdy_q[$];
  logic [N*KW-1:0] kern, box, ident;
  int tests = 0, fails = 0;
  logic s_vv, s_vr, s_wr, s_l;
  logic [31:0] s_vd;

  window_conv #(.WIN_SIZE(3)) dut (
    .clk_i(clk), .rst_i(rst), .coef_i(coef),
    .window_tvalid(wv), .window_tready(wr), .window_tdata(wd), .window_tlast(wl), .window_tuser(wu),
    .video_tvalid(vv), .video_tready(vr), .video_tdata(vd), .video_tlast(vl), .video_tuser(vu)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] conv(input logic [N*PXW-1:0] px, input logic [N*KW-1:0] k);
    logic [31:0] o;
    int s;
    o = '0;
    for (int c = 0; c < 3; c++) begin
      s = 0;
      for (int t = 0; t < N; t++) s += int'(px[t*PXW+c*CW +: CW]) * int'($signed(k[t*KW +: KW]));
      s = (s + 8) >>> 4;
      s = s < 0 ? 0 : s > 1023 ? 1023 : s;
      o[c*CW +: CW] = s[CW-1:0];
    end
    return o;
  endfunction

  function automatic logic [N*PXW-1:0] rand_win();
    logic [N*PXW-1:0] w;
    for (int t = 0; t < N; t++) w[t*PXW +: PXW] = PXW'($urandom);
    return w;
  endfunction

  function automatic logic [N*KW-1:0] rand_kern();
    logic [N*KW-1:0] k;
    for (int t = 0; t < N; t++) k[t*KW +: KW] = KW'($urandom);
    return k;
  endfunction

  function automatic logic [N*PXW-1:0] flat(input logic [9:0] v);
    logic [N*PXW-1:0] w;
    for (int t = 0; t < N; t++) w[t*PXW +: PXW] = {v, v, v};
    return w;
  endfunction

  function automatic logic [N*PXW-1:0] ramp(input int i);
    logic [N*PXW-1:0] w;
    for (int t = 0; t < N; t++)
      for (int c = 0; c < 3; c++) w[t*PXW+c*CW +: CW] = CW'((i * 37 + t * 11 + c * 5) % 1024);
    return w;
  endfunction

  task automatic tick(output bit acc);
    @(negedge clk);
    acc = wv && wr;
    if (acc) begin
      if (wu) kern = coef;
      exp_q.push_back(beat_t'{conv(wd, kern), wl, wu});
    end
    if (vv && vr) got_q.push_back(beat_t'{vd, vl, vu});
    {s_vv, s_vr, s_wr, s_vd, s_l} = {vv, vr, wr, vd, vl};
    @(posedge clk);
    #1 vr = rdy_q.size() > 0 ? rdy_q.pop_front() : 1'b1;
  endtask

  task automatic send(input logic [N*PXW-1:0] d, input logic [N*KW-1:0] k, input bit l, input bit u);
    bit acc;
    int n = 0;
    {wv, wd, coef, wl, wu} = {1'b1, d, k, l, u};
    do begin tick(acc); n++; end while (!acc && n < 300);
    wv = 0;
    if (!acc) begin tests++; fails++; $display("FAIL send_accept timed out after %0d cycles", n); end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin tick(acc); n++; end
    idle(10);
  endtask

  task automatic test_reset();
    idle(2);
    tests += 5;
    if (vv !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b want 0", vv); end
    if (vd !== 32'h0) begin fails++; $display("FAIL reset_tdata got %h want 0", vd); end
    if (vl !== 1'b0) begin fails++; $display("FAIL reset_tlast got %b want 0", vl); end
    if (vu !== 1'b0) begin fails++; $display("FAIL reset_tuser got %b want 0", vu); end
    if (wr !== 1'b1) begin fails++; $display("FAIL reset_tready got %b want 1", wr); end
    rst = 0;
    idle(1);
  endtask

  task automatic test_identity();
    logic [N*PXW-1:0] d;
    beat_t g;
    bit acc;
    int lat = 1;
    for (int t = 0; t < N; t++) d[t*PXW +: PXW] = (t == 4) ? {10'd30, 10'd20, 10'd10} : {3{10'h3FF}};
    send(d, box, 1'b1, 1'b0);
    while (got_q.size() == 0 && lat < 20) begin tick(acc); if (got_q.size() == 0) lat++; end
    g = got_q.size() > 0 ? got_q[0] : '0;
    tests += 4;
    if (lat !== 6) begin fails++; $display("FAIL ident_latency got %0d want 6", lat); end
    if (g.d !== {2'b00, 10'd30, 10'd20, 10'd10}) begin fails++; $display("FAIL ident_data got %h want %h", g.d, {2'b00, 10'd30, 10'd20, 10'd10}); end
    if (g.l !== 1'b1) begin fails++; $display("FAIL ident_tlast got %b want 1", g.l); end
    if (g.u !== 1'b0) begin fails++; $display("FAIL ident_tuser got %b want 0", g.u); end
    drain();
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_box_round();
    beat_t g;
    send(flat(10'd100), box, 1'b0, 1'b1);
    drain();
    g = got_q.size() > 0 ? got_q[0] : '0;
    tests += 3;
    if (got_q.size() !== 1) begin fails++; $display("FAIL box_count got %0d want 1", got_q.size()); end
    if (g.d !== {2'b00, {3{10'd113}}}) begin fails++; $display("FAIL box_round got %h want %h", g.d, {2'b00, {3{10'd113}}}); end
    if (g.u !== 1'b1) begin fails++; $display("FAIL box_tuser got %b want 1", g.u); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    logic [N*KW-1:0] kpos, kneg;
    beat_t g0, g1;
    kpos = '0; kpos[4*KW +: KW] = 8'd32;
    kneg = '0; kneg[4*KW +: KW] = 8'hF0;
    send(flat(10'd600), kpos, 1'b0, 1'b1);
    send(flat(10'd50), kneg, 1'b0, 1'b1);
    drain();
    g0 = got_q.size() > 0 ? got_q[0] : '0;
    g1 = got_q.size() > 1 ? got_q[1] : '1;
    tests += 3;
    if (got_q.size() !== 2) begin fails++; $display("FAIL sat_count got %0d want 2", got_q.size()); end
    if (g0.d !== {2'b00, {3{10'h3FF}}}) begin fails++; $display("FAIL sat_high got %h want %h", g0.d, {2'b00, {3{10'h3FF}}}); end
    if (g1.d !== 32'h0) begin fails++; $display("FAIL sat_low got %h want 0", g1.d); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_kernel_latch();
    logic [N*PXW-1:0] w [6];
    for (int b = 0; b < 6; b++) w[b] = rand_win();
    send(w[0], ident, 1'b0, 1'b1);
    for (int b = 1; b < 4; b++) send(w[b], box, b == 3, 1'b0);
    send(w[4], box, 1'b0, 1'b1);
    send(w[5], rand_kern(), 1'b1, 1'b0);
    drain();
    tests++;
    if (got_q.size() !== 6) begin fails++; $display("FAIL latch_count got %0d want 6", got_q.size()); end
    for (int b = 1; b < 4 && b < got_q.size(); b++) begin
      tests++;
      if (got_q[b].d !== {2'b00, w[b][4*PXW +: PXW]}) begin fails++; $display("FAIL latch_ident%0d got %h want %h", b, got_q[b].d, {2'b00, w[b][4*PXW +: PXW]}); end
    end
    for (int b = 4; b < 6 && b < got_q.size(); b++) begin
      tests++;
      if (got_q[b].d !== conv(w[b], box)) begin fails++; $display("FAIL latch_box%0d got %h want %h", b, got_q[b].d, conv(w[b], box)); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL latch_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int i = 0, cyc = 0;
    bit acc;
    logic p_vv = 0, p_vr = 1, p_l = 0;
    logic [31:0] p_vd = '0;
    for (int k = 0; k < 40; k++) rdy_q.push_back(k % 5 == 0 || k % 5 == 3);
    repeat (5) rdy_q.push_back(1'b0);
    for (int k = 0; k < 20; k++) rdy_q.push_back(k % 2 == 1);
    while ((i < 20 || got_q.size() < 20) && cyc < 500) begin
      wv = i < 20;
      if (i < 20) begin wd = ramp(i); wl = i == 19; wu = i == 0; coef = box; end
      tick(acc);
      if (acc) i++;
      tests++;
      if (s_wr !== (!s_vv || s_vr)) begin fails++; $display("FAIL bp_tready cyc %0d got %b want %b", cyc, s_wr, !s_vv || s_vr); end
      if (p_vv && !p_vr) begin
        tests++;
        if (!s_vv || s_vd !== p_vd || s_l !== p_l) begin fails++; $display("FAIL bp_hold cyc %0d got %b/%h/%b want 1/%h/%b", cyc, s_vv, s_vd, s_l, p_vd, p_l); end
      end
      {p_vv, p_vr, p_vd, p_l} = {s_vv, s_vr, s_vd, s_l};
      cyc++;
    end
    wv = 0;
    rdy_q.delete();
    drain();
    tests += 2;
    if (got_q.size() !== 20) begin fails++; $display("FAIL bp_count got %0d want 20", got_q.size()); end
    if (got_q.size() == 20 && got_q[19].l !== 1'b1) begin fails++; $display("FAIL bp_tlast got %b want 1", got_q[19].l); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL bp_beat%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) rdy_q.push_back($urandom_range(0, 3) != 0);
    for (int b = 0; b < 60; b++) begin
      send(rand_win(), rand_kern(), b % 10 == 9, b == 0 || $urandom_range(0, 5) == 0);
      idle($urandom_range(0, 1));
    end
    rdy_q.delete();
    drain();
    tests++;
    if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL rand_beat%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic [N*PXW-1:0] w;
    bit acc;
    int lat = 1;
    for (int b = 0; b < 8; b++) send(rand_win(), box, 1'b0, b == 0);
    tests += 2;
    if (vv !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %b want 1", vv); end
    if (got_q.size() !== 2) begin fails++; $display("FAIL mid_pre_count got %0d want 2", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL mid_pre_beat%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
    rst = 1;
    #1;
    tests += 2;
    if (vv !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b want 0", vv); end
    if (vd !== 32'h0) begin fails++; $display("FAIL mid_rst_data got %h want 0", vd); end
    got_q.delete(); exp_q.delete();
    kern = ident;
    idle(2);
    rst = 0;
    w = rand_win();
    send(w, box, 1'b1, 1'b0);
    while (got_q.size() == 0 && lat < 20) begin tick(acc); if (got_q.size() == 0) lat++; end
    drain();
    tests += 3;
    if (lat !== 6) begin fails++; $display("FAIL mid_latency got %0d want 6", lat); end
    if (got_q.size() !== 1) begin fails++; $display("FAIL mid_stale_count got %0d want 1", got_q.size()); end
    if (got_q.size() > 0 && got_q[0].d !== {2'b00, w[4*PXW +: PXW]}) begin fails++; $display("FAIL mid_ident got %h want %h", got_q[0].d, {2'b00, w[4*PXW +: PXW]}); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    ident = '0;
    ident[4*KW +: KW] = 8'd16;
    for (int t = 0; t < N; t++) box[t*KW +: KW] = 8'd2;
    kern = ident;
    test_reset();
    test_identity();
    test_box_round();
    test_saturation();
    test_kernel_latch();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
